// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal round per cycle, using
// four combinational quarter rounds, then feed-forward and a valid/ready output.
module chacha_block_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t        state;
  logic [RW-1:0] round_cnt;
  logic [31:0]   work    [16];
  logic [31:0]   saved   [16];
  logic [31:0]   init_w  [16];
  logic [31:0]   round_w [16];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Returns {d, c, b, a}.
  function automatic logic [127:0] quarter_round(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {d, c, b, a};
  endfunction

  always_comb begin
    init_w[0] = 32'h61707865;
    init_w[1] = 32'h3320646e;
    init_w[2] = 32'h79622d32;
    init_w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) init_w[4+i] = key[32*i +: 32];
    init_w[12] = counter;
    for (int i = 0; i < 3; i++) init_w[13+i] = nonce[32*i +: 32];
  end

  // Odd rounds rotate the b/c/d rows by 1/2/3 lanes to form the diagonals.
  always_comb begin
    logic [1:0]   odd1, odd2, odd3;
    logic [3:0]   ia, ib, ic, id;
    logic [127:0] qr;
    round_w = work;
    odd1 = round_cnt[0] ? 2'd1 : 2'd0;
    odd2 = round_cnt[0] ? 2'd2 : 2'd0;
    odd3 = round_cnt[0] ? 2'd3 : 2'd0;
    for (int j = 0; j < 4; j++) begin
      ia = {2'b00, 2'(j)};
      ib = {2'b01, 2'(j) + odd1};
      ic = {2'b10, 2'(j) + odd2};
      id = {2'b11, 2'(j) + odd3};
      qr = quarter_round(work[ia], work[ib], work[ic], work[id]);
      round_w[ia] = qr[31:0];
      round_w[ib] = qr[63:32];
      round_w[ic] = qr[95:64];
      round_w[id] = qr[127:96];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_cnt <= '0;
      out_valid <= 1'b0;
      keystream <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= init_w;
            saved     <= init_w;
            round_cnt <= '0;
            state     <= ROUND;
          end
        end
        ROUND: begin
          work      <= round_w;
          round_cnt <= round_cnt + 1'b1;
          if (round_cnt == LAST_ROUND) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 16; i++) keystream[32*i +: 32] <= work[i] + saved[i];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 vector, backpressure, busy input
// ignore, mid-operation reset, counter boundary, and an 8-round instance.
module tb_chacha_block_core;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic [511:0] keystream;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [255:0] key8;
  logic [31:0]  counter8;
  logic [95:0]  nonce8;
  logic [511:0] keystream8;

  int tests_run    = 0;
  int tests_failed = 0;
  int blocks20     = 0;

  logic [511:0] exp_q[$];

  localparam logic [255:0] RFC_KEY = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                      32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};
  localparam logic [511:0] RFC_BLOCK = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
                                        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
                                        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
                                        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  chacha_block_core #(.ROUNDS(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key),
    .counter(counter), .nonce(nonce), .out_valid(out_valid), .out_ready(out_ready),
    .keystream(keystream), .busy(busy)
  );

  chacha_block_core #(.ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .key(key8),
    .counter(counter8), .nonce(nonce8), .out_valid(out_valid8), .out_ready(out_ready8),
    .keystream(keystream8), .busy(busy8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) if (!rst && out_valid && out_ready) blocks20++;

  // ---------------- reference model ----------------
  function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] c,
                                              input logic [95:0] n, input int rounds);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [127:0] q;
    logic [511:0] res;
    int sched [8][4];
    sched = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
              '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int r = 0; r < rounds / 2; r++) begin
      for (int g = 0; g < 8; g++) begin
        q = qr_ref(x[sched[g][0]], x[sched[g][1]], x[sched[g][2]], x[sched[g][3]]);
        x[sched[g][0]] = q[31:0];
        x[sched[g][1]] = q[63:32];
        x[sched[g][2]] = q[95:64];
        x[sched[g][3]] = q[127:96];
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (start and end just after a negedge) ----------------
  task automatic send_req(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    key = k; counter = c; nonce = n; in_valid = 1'b1;
    check("accept_ready", 512'(in_ready), 512'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat);
    int k;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 512'(k), 512'(lat));
  endtask

  task automatic collect(input string tag, output logic [511:0] got);
    logic [511:0] exp;
    got = keystream;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = '0;
    check(tag, got, exp);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", 512'(in_ready), 512'(1));
    check("post_hs_out_valid", 512'(out_valid), 512'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [511:0] got, hold, ref8;
    int blk_before, seen, k, nrise;
    int rise_at [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; counter = '0; nonce = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; key8 = '0; counter8 = '0; nonce8 = '0;
    rise_at = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    check("rst_in_ready", 512'(in_ready), 512'(1));
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_keystream", keystream, 512'(0));
    check("rst8_in_ready", 512'(in_ready8), 512'(1));
    check("rst8_out_valid", 512'(out_valid8), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // RFC 8439 block function vector
    exp_q.push_back(RFC_BLOCK);
    send_req(RFC_KEY, 32'd1, RFC_NONCE);
    check("rfc_busy", 512'(busy), 512'(1));
    wait_out("rfc_latency", 21);
    check("rfc_word0", 512'(keystream[31:0]), 512'(32'he4e7f110));
    check("rfc_word1", 512'(keystream[63:32]), 512'(32'h15593bd1));
    check("rfc_word15", 512'(keystream[511:480]), 512'(32'h4e3c50a2));
    collect("rfc_block", got);
    handshake();

    // Backpressure: hold out_ready low for 10 cycles
    exp_q.push_back(RFC_BLOCK);
    send_req(RFC_KEY, 32'd1, RFC_NONCE);
    wait_out("bp_latency", 21);
    hold = keystream;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_keystream_stable", keystream, hold);
      check("bp_out_valid", 512'(out_valid), 512'(1));
      check("bp_in_ready", 512'(in_ready), 512'(0));
      check("bp_busy", 512'(busy), 512'(1));
    end
    collect("bp_block", got);
    handshake();

    // Inputs change and in_valid pulses while busy
    blk_before = blocks20;
    exp_q.push_back(RFC_BLOCK);
    send_req(RFC_KEY, 32'd1, RFC_NONCE);
    repeat (5) @(negedge clk);
    key = ~RFC_KEY; counter = 32'h12345678; nonce = 96'hdeadbeef_cafef00d_01234567;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_out("busy_latency", 13);
    collect("busy_block", got);
    handshake();
    repeat (30) @(negedge clk);
    check("busy_one_block", 512'(blocks20 - blk_before), 512'(1));
    check("busy_no_extra_valid", 512'(out_valid), 512'(0));

    // Reset at round 7
    send_req(RFC_KEY, 32'd1, RFC_NONCE);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 512'(in_ready), 512'(1));
    check("midrst_out_valid", 512'(out_valid), 512'(0));
    check("midrst_busy", 512'(busy), 512'(0));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_block", 512'(seen), 512'(0));
    exp_q.push_back(RFC_BLOCK);
    send_req(RFC_KEY, 32'd1, RFC_NONCE);
    wait_out("midrst_latency", 21);
    collect("midrst_fresh_block", got);
    handshake();

    // Counter boundary
    exp_q.push_back(chacha_ref('0, 32'hffffffff, '0, 20));
    send_req('0, 32'hffffffff, '0);
    wait_out("ctrmax_latency", 21);
    collect("ctrmax_block", got);
    check("ctrmax_differs_from_next", 512'(got != chacha_ref('0, 32'h0, 96'h1, 20)), 512'(1));
    handshake();
    exp_q.push_back(chacha_ref('0, 32'h0, '0, 20));
    send_req('0, 32'h0, '0);
    wait_out("ctr0_latency", 21);
    collect("ctr0_block", got);
    check("ctr0_word0", 512'(got[31:0]), 512'(32'hade0b876));
    handshake();

    // 8-round instance, all-zero inputs
    ref8 = chacha_ref('0, 32'h0, '0, 8);
    in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("c8_latency", 512'(k), 512'(9));
    check("c8_block", keystream8, ref8);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("c8_post_hs_in_ready", 512'(in_ready8), 512'(1));

    // Back-to-back with in_valid and out_ready held high
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    nrise = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (out_valid8) begin
        if (nrise < 4) rise_at[nrise] = c;
        nrise++;
        check("c8_b2b_block", keystream8, ref8);
      end
    end
    in_valid8 = 1'b0;
    check("c8_b2b_count", 512'(nrise), 512'(4));
    check("c8_b2b_gap1", 512'(rise_at[1] - rise_at[0]), 512'(11));
    check("c8_b2b_gap2", 512'(rise_at[2] - rise_at[1]), 512'(11));
    repeat (15) @(negedge clk);
    out_ready8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/chacha_block_core.md
Name: chacha_block_core

Overview:
Iterative ChaCha20 block function that sits directly above quarter_round. It builds the 16-word initial state from constants, key, block counter and nonce, then runs ROUNDS rounds using four combinational quarter_round instances. Column and diagonal rounds alternate, one round per cycle. It then adds the initial state back in (feed-forward) and presents a 512-bit keystream block on a valid/ready output port.

Parameters:
ROUNDS, 20, number of rounds (one column or diagonal pass each); must be even and >= 2; legal values 8, 12, 20.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request carries a valid key/nonce/counter
in_ready  output  1  core can accept a request (high only in IDLE)
key  input  256  key; key[32*i+31:32*i] = state word 4+i, i=0..7
counter  input  32  block counter; state word 12
nonce  input  96  nonce; nonce[32*i+31:32*i] = state word 13+i, i=0..2
out_valid  output  1  keystream block valid
out_ready  input  1  downstream accepts keystream
keystream  output  512  keystream[32*i+31:32*i] = final state word i, i=0..15
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clk edge with rst=1 forces state IDLE. Outputs after reset: in_ready=1, out_valid=0, busy=0, keystream=0, round counter=0. Reset overrides every other input in every state, including mid-round and while out_valid=1; any partial block is discarded and never emitted.
- Initial state: w0..w3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; w4..w11 = key; w12 = counter; w13..w15 = nonce. All words are little-endian 32-bit.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: in_ready=1. If in_valid=1 at an edge, latch the initial state into both a working register and a saved copy, clear the round counter, and go to ROUND. Otherwise stay in IDLE.
- ROUND: one round per cycle.
  - Round counter even = column round: QR(0,4,8,12), QR(1,5,9,13), QR(2,6,10,14), QR(3,7,11,15).
  - Round counter odd = diagonal round: QR(0,5,10,15), QR(1,6,11,12), QR(2,7,8,13), QR(3,4,9,14).
  - QR argument order is (a,b,c,d). Results are written back to the same word indices.
  - The counter increments each cycle. After the round with counter = ROUNDS-1, go to FINAL.
- FINAL: keystream word i = working word i + saved word i, mod 2^32 (per-word carry discarded). Register the result, set out_valid=1, go to DONE.
- DONE: keystream and out_valid are held stable. When out_valid and out_ready are both high at an edge, clear out_valid and go to IDLE. keystream may keep its last value after that.
- Latency: request accepted at edge N means out_valid is high after edge N+ROUNDS+1 (N+21 for the default). Throughput is at most one block per ROUNDS+3 cycles.
- While busy, in_valid is ignored and key/counter/nonce may change freely; only the values latched at acceptance are used.
- Simultaneous events: the request and its accepting edge in IDLE need no special handling. rst together with in_valid: rst wins, so nothing is accepted. rst together with an out_ready handshake: rst wins.
- Counter wrap is the caller's job: counter=0xffffffff is used as-is, with no increment and no carry into the nonce.
- Round counter width is $clog2(ROUNDS). It is never compared against values >= ROUNDS.

Test Plan:
- RFC 8439 §2.3.2 vector:
  - Stimulus: key bytes 00..1f (key[31:0]=0x03020100), counter=1, nonce words 0x09000000, 0x4a000000, 0x00000000.
  - Required: keystream word0=0xe4e7f110, word1=0x15593bd1, word15=0x4e3c50a2, and the full block matches the RFC.
  - Required: out_valid rises exactly 21 cycles after the accepting edge.
- Backpressure: same vector with out_ready=0 for 10 cycles after out_valid rises. Required: keystream and out_valid stay stable, in_ready=0 and busy=1 throughout. out_ready=1 for one cycle completes the handshake; the next cycle shows in_ready=1 and out_valid=0.
- Busy input ignore: change key/nonce/counter and pulse in_valid during ROUND. Required: output still equals the original vector's result, and exactly one block is produced.
- Reset mid-operation: assert rst for 1 cycle at round 7. Required: the next cycle shows in_ready=1, out_valid=0, busy=0, and no block appears. A fresh request afterwards yields the correct result.
- Counter boundary: key=0, nonce=0, counter=0xffffffff. Required: the result matches the software model with w12=0xffffffff and w13=0. Repeat with counter=0 and check both results against the model.
- ROUNDS=8 instance, all-zero key/nonce/counter. Required: out_valid is high 9 cycles after acceptance and the keystream matches the ChaCha8 reference model. Back-to-back requests (in_valid held high) produce one block per 11 cycles.
